// File: rtl/svc_axi_burst_merge_b.sv
// rtl/svc_axi_burst_merge_b.sv - merges per-beat B responses back into one B per original AW burst
// Burst boundaries come from a FIFO of t_last flags captured on the iterator's issue tap.
module svc_axi_burst_merge_b #(
  parameter int AXI_ID_WIDTH = 4,
  parameter int DEPTH        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    t_valid,
  input  logic [AXI_ID_WIDTH-1:0] t_id,
  input  logic                    t_last,
  output logic                    t_ready,
  input  logic                    s_bvalid,
  input  logic [AXI_ID_WIDTH-1:0] s_bid,
  input  logic [1:0]              s_bresp,
  output logic                    s_bready,
  output logic                    m_bvalid,
  output logic [AXI_ID_WIDTH-1:0] m_bid,
  output logic [1:0]              m_bresp,
  input  logic                    m_bready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [DEPTH-1:0] last_q;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [1:0]       acc;

  logic       push;
  logic       pop;
  logic       head_last;
  logic [1:0] merged;

  // Responses come back in issue order, so the tap id only matters upstream.
  logic unused_tap_id;
  assign unused_tap_id = ^t_id;

  // Both readies come from registers only; no path from m_bready to s_bready.
  assign t_ready   = (count != FULL_COUNT);
  assign s_bready  = (count != '0) && !m_bvalid;
  assign push      = t_valid && t_ready;
  assign pop       = s_bvalid && s_bready;
  assign head_last = last_q[rd_ptr];
  assign merged    = (s_bresp > acc) ? s_bresp : acc;

  always_ff @(posedge clk) begin
    if (push) begin
      last_q[wr_ptr] <= t_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // A pop can only happen with m_bvalid low, so set and clear never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= 2'b00;
      m_bvalid <= 1'b0;
      m_bid    <= '0;
      m_bresp  <= 2'b00;
    end else begin
      if (m_bvalid && m_bready) begin
        m_bvalid <= 1'b0;
      end
      if (pop) begin
        if (head_last) begin
          m_bvalid <= 1'b1;
          m_bid    <= s_bid;
          m_bresp  <= merged;
          acc      <= 2'b00;
        end else begin
          acc <= merged;
        end
      end
    end
  end

endmodule

// File: tb/tb_svc_axi_burst_merge_b.sv
// tb/tb_svc_axi_burst_merge_b.sv - randomized and directed bench for svc_axi_burst_merge_b
// A queue-based model of outstanding beats predicts every output each cycle.
module tb_svc_axi_burst_merge_b;

  localparam int IDW   = 4;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           t_valid;
  logic [IDW-1:0] t_id;
  logic           t_last;
  logic           t_ready;
  logic           s_bvalid;
  logic [IDW-1:0] s_bid;
  logic [1:0]     s_bresp;
  logic           s_bready;
  logic           m_bvalid;
  logic [IDW-1:0] m_bid;
  logic [1:0]     m_bresp;
  logic           m_bready;

  int total  = 0;
  int passed = 0;
  bit chk_en = 1'b0;

  svc_axi_burst_merge_b #(.AXI_ID_WIDTH(IDW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .t_valid(t_valid), .t_id(t_id), .t_last(t_last), .t_ready(t_ready),
    .s_bvalid(s_bvalid), .s_bid(s_bid), .s_bresp(s_bresp), .s_bready(s_bready),
    .m_bvalid(m_bvalid), .m_bid(m_bid), .m_bresp(m_bresp), .m_bready(m_bready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: outstanding t_last flags, worst resp so far, and the pending merged B.
  bit         mq[$];
  logic [1:0] m_acc;
  bit         mv;
  logic [IDW-1:0] mid;
  logic [1:0] mresp;

  always @(posedge clk) begin
    bit can_push, can_pop, hl;
    logic [1:0] worst;
    if (rst) begin
      mq.delete();
      m_acc = 2'b00;
      mv    = 1'b0;
      mid   = '0;
      mresp = 2'b00;
    end else begin
      can_push = t_valid && (mq.size() != DEPTH);
      can_pop  = s_bvalid && (mq.size() != 0) && !mv;
      if (mv && m_bready) mv = 1'b0;
      if (can_pop) begin
        hl    = mq.pop_front();
        worst = (s_bresp > m_acc) ? s_bresp : m_acc;
        if (hl) begin
          mv    = 1'b1;
          mid   = s_bid;
          mresp = worst;
          m_acc = 2'b00;
        end else begin
          m_acc = worst;
        end
      end
      if (can_push) mq.push_back(t_last);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("t_ready", t_ready, mq.size() != DEPTH);
      check("s_bready", s_bready, (mq.size() != 0) && !mv);
      check("m_bvalid", m_bvalid, mv);
      if (mv) begin
        check("m_bid", m_bid, mid);
        check("m_bresp", m_bresp, mresp);
      end
    end
  end

  task automatic tap(input logic [IDW-1:0] id, input logic last);
    int n = 0;
    t_valid = 1'b1; t_id = id; t_last = last;
    while (!t_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!t_ready) check("tap_timeout", 0, 1);
    @(posedge clk); #1;
    t_valid = 1'b0;
  endtask

  task automatic send_b(input logic [IDW-1:0] id, input logic [1:0] r);
    int n = 0;
    s_bvalid = 1'b1; s_bid = id; s_bresp = r;
    while (!s_bready && n < 50) begin @(posedge clk); #1; n++; end
    if (!s_bready) check("s_b_timeout", 0, 1);
    @(posedge clk); #1;
    s_bvalid = 1'b0;
  endtask

  // Burst of n beats (n <= DEPTH); beat i responds with resps[2*i +: 2].
  task automatic run_burst(input logic [IDW-1:0] id, input int n, input logic [7:0] resps,
                           input logic [1:0] exp);
    for (int i = 0; i < n; i++) tap(id, i == n - 1);
    for (int i = 0; i < n; i++) begin
      send_b(id, resps[2*i +: 2]);
      if (i < n - 1) check("no_early_mvalid", m_bvalid, 0);
    end
    check("burst_mvalid", m_bvalid, 1);
    check("burst_bid", m_bid, id);
    check("burst_bresp", m_bresp, exp);
    @(posedge clk); #1;
    check("burst_mvalid_clear", m_bvalid, 0);
  endtask

  initial begin
    rst = 1'b1; t_valid = 0; t_id = 0; t_last = 0;
    s_bvalid = 0; s_bid = 0; s_bresp = 0; m_bready = 0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    check("rst_m_bvalid", m_bvalid, 0);
    check("rst_s_bready", s_bready, 0);
    check("rst_t_ready", t_ready, 1);
    check("rst_m_bresp", m_bresp, 0);
    check("rst_m_bid", m_bid, 0);
    rst = 1'b0;
    m_bready = 1'b1;

    run_burst(4'hD, 4, 8'b00_00_00_00, 2'b00);
    run_burst(4'h3, 4, 8'b00_00_00_10, 2'b10);
    run_burst(4'h7, 2, 8'b00_00_00_00, 2'b00);
    run_burst(4'h9, 1, 8'b00_00_00_11, 2'b11);
    run_burst(4'hA, 3, 8'b00_00_10_11, 2'b11);

    // Fill, pop once, then push and pop together at count 3.
    for (int i = 0; i < 4; i++) tap(4'h1, i == 3);
    check("full_t_ready", t_ready, 0);
    send_b(4'h1, 2'b00);
    check("after_pop_t_ready", t_ready, 1);
    t_valid = 1'b1; t_id = 4'h1; t_last = 1'b1;
    s_bvalid = 1'b1; s_bid = 4'h1; s_bresp = 2'b01;
    check("simul_s_bready", s_bready, 1);
    @(posedge clk); #1;
    t_valid = 1'b0; s_bvalid = 1'b0;
    check("simul_t_ready", t_ready, 1);
    tap(4'h2, 1'b1);
    check("refull_t_ready", t_ready, 0);
    for (int i = 0; i < 4; i++) send_b(4'h1, 2'b01);
    repeat (2) @(posedge clk); #1;

    // Backpressure on the merged channel.
    m_bready = 1'b0;
    tap(4'h5, 1'b1);
    tap(4'h6, 1'b1);
    send_b(4'h5, 2'b10);
    s_bvalid = 1'b1; s_bid = 4'h6; s_bresp = 2'b01;
    for (int i = 0; i < 5; i++) begin
      check("hold_m_bvalid", m_bvalid, 1);
      check("hold_m_bid", m_bid, 4'h5);
      check("hold_m_bresp", m_bresp, 2'b10);
      check("hold_s_bready", s_bready, 0);
      @(posedge clk); #1;
    end
    m_bready = 1'b1;
    @(posedge clk); #1;
    check("release_m_bvalid", m_bvalid, 0);
    check("release_s_bready", s_bready, 1);
    @(posedge clk); #1;
    s_bvalid = 1'b0;
    check("second_m_bvalid", m_bvalid, 1);
    check("second_m_bid", m_bid, 4'h6);
    check("second_m_bresp", m_bresp, 2'b01);
    @(posedge clk); #1;

    // Random traffic, including occasional mid-burst resets.
    for (int c = 0; c < 4000; c++) begin
      rst      = ($urandom_range(0, 499) == 0);
      t_valid  = $urandom_range(0, 1);
      t_id     = IDW'($urandom);
      t_last   = ($urandom_range(0, 2) == 0);
      s_bvalid = ($urandom_range(0, 2) != 0);
      s_bid    = IDW'($urandom);
      s_bresp  = 2'($urandom);
      m_bready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; t_valid = 1'b0; s_bvalid = 1'b0; m_bready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
